fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Instruction-fetch front end of the RISC-V core. Holds the PC and issues word-addressed requests to instruction memory over a req/gnt handshake.
- Buffers in-order responses in a small FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects carrying a byte-address target produced by the branch/jump target path. Flushes in-flight and buffered fetches on redirect.

Parameters:
- ADDR_W, `ADDR_WIDTH (32), byte-address width from system_param.vh
- DATA_W, 32, instruction width
- BUF_DEPTH, 2, fetch-buffer entries and maximum in-flight requests (power of 2, >=2)
- RESET_PC, 32'h0000_0000, first fetch byte address after reset

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  load new PC this cycle (branch/jump/trap)
- redirect_pc  in  ADDR_W  redirect target, byte address
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W-2  word address (pc[ADDR_W-1:2])
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (in order, exactly one per grant, earliest 1 cycle after gnt)
- imem_rdata  in  DATA_W  instruction word
- if_valid  out  1  buffer head valid toward decode
- if_ready  in  1  decode accepts head
- if_pc  out  ADDR_W  byte PC of head instruction
- if_instr  out  DATA_W  head instruction
- misalign_err  out  1  held high while halted on misaligned target

Behaviour:
- Reset (async assert, sync deassert): state=BOOT, pc=RESET_PC, fifo empty, outstanding=0, kill=0. Outputs: imem_req=0, if_valid=0, misalign_err=0, if_pc=0, if_instr=0.
- State BOOT: lasts exactly one cycle after rst_n rises, then RUN.
- State RUN:
  - imem_req=1 when (outstanding + fifo_count) < BUF_DEPTH and redirect_valid=0.
  - imem_addr = pc[ADDR_W-1:2]. It is combinational from the pc register and stable until gnt.
  - On req&gnt: pc += 4 (wraps modulo 2^ADDR_W), outstanding += 1, and the issued PC is pushed into an in-flight PC queue.
- On imem_rvalid:
  - outstanding -= 1 and the in-flight PC is popped.
  - If kill>0: kill -= 1 and the data is dropped.
  - Otherwise {pc, rdata} is pushed into the fifo. It is visible on if_* the next cycle (1-cycle registered latency, rvalid->if_valid).
- Decode handshake:
  - if_valid&if_ready pops the head.
  - Push and pop in the same cycle are allowed at any occupancy.
  - The credit rule guarantees push-while-full never occurs (bench asserts it).
- Redirect (redirect_valid=1, any state except BOOT):
  - Same cycle: imem_req=0 (withdrawal allowed), fifo flushed, if_valid=0 from the next cycle.
  - kill <= outstanding (net of any rvalid in the same cycle, which is itself discarded).
  - Aligned target (redirect_pc[1:0]==0): pc <= redirect_pc; state RUN. The first request for the target is issued on cycle N+1 if credits allow.
  - Misaligned target: state HALT, misalign_err=1 from N+1. pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
- State HALT:
  - No requests issued; outstanding responses are still drained into kill.
  - misalign_err stays high until an aligned redirect, which clears it the next cycle and returns to RUN.
- Simultaneous events:
  - redirect has priority over gnt (gnt cannot occur since req=0).
  - Redirect plus if_ready: the pop is irrelevant because the flush wins.
- Counters: outstanding, kill and fifo_count are each width clog2(BUF_DEPTH)+1 and never exceed BUF_DEPTH.

Decomposition:
- Shared package/header (extend system_param.vh):
  - fetch state encoding (BOOT, RUN, HALT)
  - RESET_PC default
  - INSTR_WIDTH
- Sub-module: fetch_fifo, a parameterised sync FIFO with {pc,instr} entries, flush, count, push/pop.
- The in-flight PC queue reuses fetch_fifo with DATA_W=0 or a separate instance.

Test Plan:
- Reset then free-running: imem_gnt=1, rvalid 1 cycle after gnt, if_ready=1 -> imem_addr 0x0,0x1,0x2…; if_pc 0x0,0x4,0x8 with matching instr; first if_valid 3 cycles after rst_n rises.
- Backpressure: if_ready=0 -> exactly BUF_DEPTH(2) grants, then imem_req=0. Releasing if_ready resumes in order with no loss or duplication.
- Redirect with 2 in flight: redirect_pc=0x100 at cycle N. Both old responses are dropped, imem_addr=0x40 at N+1, the next if_pc is 0x100.
- Redirect coincident with rvalid and if_valid: the response is dropped, the fifo is flushed, and the first delivered if_pc equals the target.
- Misaligned redirect 0x102: misalign_err=1 from N+1, no imem_req. A later redirect 0x200 clears misalign_err and the first if_pc is 0x200.
- PC wrap: RESET_PC=0xFFFFFFFC -> if_pc 0xFFFFFFFC then 0x00000000. Also async reset asserted mid-fetch clears all outputs immediately.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, reset PC
// and the fetch state encoding.
package fetch_pc_gen_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_fifo.sv
// Small synchronous FIFO with flush and occupancy count. Used both for the
// {pc, instr} fetch buffer and for the queue of issued-but-unanswered PCs.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; validity is carried by count_q, and
  // leaving it unreset lets it map onto plain flops or RAM without reset muxes.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator: issues word-addressed fetches under a credit
// limit, buffers in-order responses and handles aligned/misaligned redirects.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_WIDTH,
  parameter int                DATA_W    = INSTR_WIDTH,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              misalign_err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     kill_q, kill_d;

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credits_used;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;
  logic              redirect_act;
  logic              issue;
  logic              buf_push;
  logic              buf_pop;

  assign redirect_act = redirect_valid && (state_q != ST_BOOT);
  assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue        = imem_req && imem_gnt;
  assign buf_push     = imem_rvalid && (kill_q == '0) && !redirect_act;
  assign buf_pop      = if_valid && if_ready && !redirect_act;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    imem_req = 1'b0;

    if (imem_rvalid && kill_q != '0) kill_d = kill_q - CW'(1);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        imem_req = !redirect_valid && (credits_used < (CW+1)'(BUF_DEPTH));
        if (imem_req && imem_gnt) pc_d = pc_q + ADDR_W'(4);
      end
      default: ;
    endcase

    // Every response still in flight belongs to the abandoned path; one
    // arriving this cycle is already being discarded.
    if (redirect_act) begin
      kill_d  = outstanding - (imem_rvalid ? CW'(1) : CW'(0));
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      state_d = (redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (BUF_DEPTH)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (issue),
    .push_data (pc_q),
    .pop       (imem_rvalid),
    .head_data (rsp_pc),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_act),
    .push      (buf_push),
    .push_data ({rsp_pc, imem_rdata}),
    .pop       (buf_pop),
    .head_data ({head_pc, head_instr}),
    .count     (fifo_count)
  );

  assign imem_addr    = pc_q[ADDR_W-1:2];
  assign if_valid     = (fifo_count != '0);
  assign if_pc        = if_valid ? head_pc : '0;
  assign if_instr     = if_valid ? head_instr : '0;
  assign misalign_err = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios followed by random
// traffic, all compared against a transaction-level model of fetch behaviour.
module tb_fetch_pc_gen;

  localparam int BUF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_pc_gen #(.BUF_DEPTH(BUF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  typedef struct {
    logic [29:0] word;
    int          due;
  } rsp_t;

  int          passes = 0;
  int          fails  = 0;
  rsp_t        pend[$];
  logic [31:0] buf_q[$];
  logic [29:0] exp_fetch;
  logic [31:0] target;
  bit          halted, booted, want_target;
  int          to_drop, cyc, grant_cnt;
  int          dly_min = 1, dly_max = 1;

  function automatic logic [31:0] mem_fn(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    buf_q.delete();
    exp_fetch   = '0;
    target      = '0;
    want_target = 1'b1;
    halted      = 1'b0;
    booted      = 1'b0;
    to_drop     = 0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    if_ready       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock of stimulus: drive at negedge, check, then advance the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit ready, input int gnt_pct);
    bit          rv, hs, granted, exp_req;
    logic [29:0] rv_word;
    @(negedge clk);
    rv             = (pend.size() > 0) && (pend[0].due <= cyc);
    rv_word        = rv ? pend[0].word : '0;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_fn(rv_word) : 32'h0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = ready;
    imem_gnt       = 1'b0;
    #1;
    exp_req = booted && !halted && !redir && (pend.size() + buf_q.size() < BUF);
    check("imem_req", imem_req, exp_req);
    check("if_valid", if_valid, buf_q.size() > 0);
    check("misalign_err", misalign_err, halted);
    if (buf_q.size() > 0) begin
      check("if_pc", if_pc, buf_q[0]);
      check("if_instr", if_instr, mem_fn(buf_q[0][31:2]));
    end
    hs = if_valid && ready && !redir;
    if (hs && want_target) begin
      check("first_pc_after_redirect", if_pc, target);
      want_target = 1'b0;
    end
    if (imem_req) imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    granted = imem_req && imem_gnt;
    if (granted) check("imem_addr", imem_addr, exp_fetch);

    if (rv) void'(pend.pop_front());
    if (redir) begin
      buf_q.delete();
      to_drop     = pend.size();
      exp_fetch   = rpc[31:2];
      halted      = (rpc[1:0] != 2'b00);
      target      = {rpc[31:2], 2'b00};
      want_target = 1'b1;
    end else begin
      if (hs) void'(buf_q.pop_front());
      if (rv) begin
        if (to_drop > 0) to_drop--;
        else begin
          check("no_push_while_full", buf_q.size() < BUF, 1);
          buf_q.push_back({rv_word, 2'b00});
        end
      end
      if (granted) begin
        pend.push_back('{exp_fetch, cyc + $urandom_range(dly_max, dly_min)});
        exp_fetch++;
        grant_cnt++;
      end
    end
    booted = 1'b1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_valid, g0;
    bit hit;
    cyc = 0;
    grant_cnt = 0;

    // Start-up: free-running fetch, first if_valid on the fourth sampled cycle.
    do_reset();
    first_valid = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1, 100);
      if (if_valid && first_valid < 0) first_valid = i;
    end
    check("first_if_valid_cycle", first_valid, 3);
    repeat (10) cycle(1'b0, '0, 1'b1, 100);

    // Backpressure: exactly BUF grants, then the request drops.
    do_reset();
    g0 = grant_cnt;
    repeat (10) cycle(1'b0, '0, 1'b0, 100);
    check("backpressure_grants", grant_cnt - g0, BUF);
    check("backpressure_req_low", imem_req, 0);
    repeat (12) cycle(1'b0, '0, 1'b1, 100);

    // Redirect to 0x100 with both slots in flight.
    dly_min = 3; dly_max = 3;
    repeat (6) cycle(1'b0, '0, 1'b1, 100);
    cycle(1'b1, 32'h0000_0100, 1'b1, 100);
    cycle(1'b0, '0, 1'b1, 100);
    check("redirect_addr", imem_addr, 30'h40);
    repeat (12) cycle(1'b0, '0, 1'b1, 100);

    // Redirect landing on the same cycle as a response and a valid head.
    dly_min = 1; dly_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && buf_q.size() > 0) begin
        cycle(1'b1, 32'h0000_0300, 1'b1, 100);
        hit = 1'b1;
      end else cycle(1'b0, '0, 1'b1, 100);
    end
    check("coincident_redirect_hit", hit, 1);
    repeat (8) cycle(1'b0, '0, 1'b1, 100);

    // Misaligned redirect halts; aligned redirect resumes.
    cycle(1'b1, 32'h0000_0102, 1'b1, 100);
    repeat (6) cycle(1'b0, '0, 1'b1, 100);
    check("halt_err_high", misalign_err, 1);
    cycle(1'b1, 32'h0000_0200, 1'b1, 100);
    repeat (10) cycle(1'b0, '0, 1'b1, 100);

    // PC wraps past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 100);
    repeat (12) cycle(1'b0, '0, 1'b1, 100);

    // Random traffic with random redirects.
    dly_min = 1; dly_max = 3;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      bit redir;
      redir = ($urandom_range(99) < 3);
      rpc   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
      cycle(redir, rpc, $urandom_range(99) < 70, 60);
    end

    // Asynchronous reset in the middle of fetching.
    dly_min = 1; dly_max = 1;
    cycle(1'b1, 32'h0000_0400, 1'b1, 100);
    repeat (5) cycle(1'b0, '0, 1'b1, 100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_imem_req", imem_req, 0);
    check("async_rst_if_valid", if_valid, 0);
    check("async_rst_misalign", misalign_err, 0);
    check("async_rst_if_pc", if_pc, 0);
    check("async_rst_if_instr", if_instr, 0);
    do_reset();
    repeat (10) cycle(1'b0, '0, 1'b1, 100);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
